// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch hazard controller for the 5-stage pipe: drives PC and IF/ID enables,
// the IF/ID flush and the ID/EX bubble, with multi-cycle stall/flush windows and event counters.
module hazard_stall_ctrl #(
    parameter int unsigned register_addr = 5,
    parameter int unsigned STALL_CYCLES  = 1,
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [register_addr-1:0] id_rs,
    input  logic [register_addr-1:0] id_rt,
    input  logic                     id_uses_rt,
    input  logic                     mem_r_pip,
    input  logic [register_addr-1:0] rt_pip,
    input  logic                     branch_taken,
    input  logic                     cnt_clr,
    output logic                     pc_w_en,
    output logic                     ifid_w_en,
    output logic                     ifid_flush,
    output logic                     stall_ctr,
    output logic                     busy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int unsigned REM_MAX = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int unsigned REM_W   = (REM_MAX > 1) ? $clog2(REM_MAX + 1) : 1;
    localparam logic [REM_W-1:0] STALL_REM =
        (STALL_CYCLES > 1) ? REM_W'(STALL_CYCLES - 2) : '0;
    localparam logic [REM_W-1:0] FLUSH_REM =
        (FLUSH_CYCLES > 1) ? REM_W'(FLUSH_CYCLES - 2) : '0;

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             haz;
    logic             stall_inc, flush_inc;

    // rt_pip==0 excludes r0, so a zero source register can never match.
    assign haz = mem_r_pip && (rt_pip != '0) &&
                 ((rt_pip == id_rs) || (id_uses_rt && (rt_pip == id_rt)));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pc_w_en    = 1'b1;
        ifid_w_en  = 1'b1;
        ifid_flush = 1'b0;
        stall_ctr  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (branch_taken) begin
            // A taken branch overrides any stall or flush in progress.
            ifid_flush = 1'b1;
            stall_ctr  = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                rem_d   = FLUSH_REM;
            end else begin
                state_d = StRun;
                rem_d   = '0;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (haz) begin
                        pc_w_en   = 1'b0;
                        ifid_w_en = 1'b0;
                        stall_ctr = 1'b1;
                        stall_inc = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = StStall;
                            rem_d   = STALL_REM;
                        end
                    end
                end
                StStall: begin
                    pc_w_en   = 1'b0;
                    ifid_w_en = 1'b0;
                    stall_ctr = 1'b1;
                    if (rem_q == '0) state_d = StRun;
                    else             rem_d   = rem_q - 1'b1;
                end
                StFlush: begin
                    ifid_flush = 1'b1;
                    stall_ctr  = 1'b1;
                    if (rem_q == '0) state_d = StRun;
                    else             rem_d   = rem_q - 1'b1;
                end
                default: begin
                    state_d = StRun;
                    rem_d   = '0;
                end
            endcase
        end

        // Outputs are forced to the idle pattern while reset is held.
        if (!rstn) begin
            pc_w_en    = 1'b1;
            ifid_w_en  = 1'b1;
            ifid_flush = 1'b0;
            stall_ctr  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StRun;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (cnt_clr) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
                if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign busy      = rstn && (state_q != StRun);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three parameterisations share one stimulus stream,
// each phase checks only the instance it targets.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rstn;
    logic [4:0] id_rs, id_rt, rt_pip;
    logic       id_uses_rt, mem_r_pip, branch_taken, cnt_clr;

    logic        a_pc, a_ifid, a_flush, a_stall, a_busy;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_pc, b_ifid, b_flush, b_stall, b_busy;
    logic [15:0] b_scnt, b_fcnt;
    logic        c_pc, c_ifid, c_flush, c_stall, c_busy;
    logic [1:0]  c_scnt, c_fcnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_ctrl u_a (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .mem_r_pip(mem_r_pip), .rt_pip(rt_pip), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_w_en(a_pc), .ifid_w_en(a_ifid), .ifid_flush(a_flush), .stall_ctr(a_stall),
        .busy(a_busy), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_stall_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(3)) u_b (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .mem_r_pip(mem_r_pip), .rt_pip(rt_pip), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_w_en(b_pc), .ifid_w_en(b_ifid), .ifid_flush(b_flush), .stall_ctr(b_stall),
        .busy(b_busy), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    hazard_stall_ctrl #(.CNT_W(2)) u_c (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .mem_r_pip(mem_r_pip), .rt_pip(rt_pip), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_w_en(c_pc), .ifid_w_en(c_ifid), .ifid_flush(c_flush), .stall_ctr(c_stall),
        .busy(c_busy), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; rt_pip = '0;
        id_uses_rt = 1'b0; mem_r_pip = 1'b0; branch_taken = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        // Reset with a live hazard on the inputs: outputs must still be idle.
        idle_inputs();
        rstn = 1'b0;
        mem_r_pip = 1'b1; rt_pip = 5'd5; id_rs = 5'd5;
        tick();
        tick();
        chk("rst_pc",    a_pc,    1);
        chk("rst_ifid",  a_ifid,  1);
        chk("rst_flush", a_flush, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_scnt",  a_scnt,  0);
        chk("rst_fcnt",  a_fcnt,  0);

        // 1: single-cycle load-use stall
        rstn = 1'b1;
        #1;
        chk("t1_pc",    a_pc,    0);
        chk("t1_ifid",  a_ifid,  0);
        chk("t1_stall", a_stall, 1);
        chk("t1_flush", a_flush, 0);
        tick();
        mem_r_pip = 1'b0;
        #1;
        chk("t1_pc_after",    a_pc,    1);
        chk("t1_stall_after", a_stall, 0);
        chk("t1_scnt",        a_scnt,  1);

        // 2: r0 never matches; rt match ignored unless id_uses_rt
        mem_r_pip = 1'b1; rt_pip = 5'd0; id_rs = 5'd0;
        #1;
        chk("t2_r0_stall", a_stall, 0);
        chk("t2_r0_pc",    a_pc,    1);
        tick();
        chk("t2_r0_scnt",  a_scnt,  1);
        rt_pip = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("t2_nort_stall", a_stall, 0);
        id_uses_rt = 1'b1;
        #1;
        chk("t2_rt_stall", a_stall, 1);
        tick();
        idle_inputs();
        #1;
        chk("t2_rt_scnt", a_scnt, 2);

        // 3: three-cycle stall
        do_reset();
        mem_r_pip = 1'b1; rt_pip = 5'd5; id_rs = 5'd5;
        #1;
        chk("t3_c1_stall", b_stall, 1);
        chk("t3_c1_busy",  b_busy,  0);
        tick();
        mem_r_pip = 1'b0;
        #1;
        chk("t3_c2_stall", b_stall, 1);
        chk("t3_c2_busy",  b_busy,  1);
        chk("t3_c2_pc",    b_pc,    0);
        tick();
        chk("t3_c3_stall", b_stall, 1);
        chk("t3_c3_busy",  b_busy,  1);
        tick();
        chk("t3_c4_stall", b_stall, 0);
        chk("t3_c4_busy",  b_busy,  0);
        chk("t3_c4_pc",    b_pc,    1);
        chk("t3_scnt",     b_scnt,  1);

        // 4: branch beats hazard in RUN
        do_reset();
        mem_r_pip = 1'b1; rt_pip = 5'd5; id_rs = 5'd5; branch_taken = 1'b1;
        #1;
        chk("t4_flush", a_flush, 1);
        chk("t4_pc",    a_pc,    1);
        chk("t4_stall", a_stall, 1);
        tick();
        idle_inputs();
        #1;
        chk("t4_scnt",   a_scnt,  0);
        chk("t4_fcnt",   a_fcnt,  1);
        chk("t4_flush2", a_flush, 0);

        // 5: branch during stall, then reset in the middle of the flush
        do_reset();
        mem_r_pip = 1'b1; rt_pip = 5'd5; id_rs = 5'd5;
        tick();
        mem_r_pip = 1'b0; branch_taken = 1'b1;
        #1;
        chk("t5_br_flush", b_flush, 1);
        chk("t5_br_pc",    b_pc,    1);
        chk("t5_br_stall", b_stall, 1);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t5_fl_busy",  b_busy,  1);
        chk("t5_fl_flush", b_flush, 1);
        chk("t5_fl_pc",    b_pc,    1);
        chk("t5_fl_stall", b_stall, 1);
        chk("t5_fl_fcnt",  b_fcnt,  1);
        chk("t5_fl_scnt",  b_scnt,  1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_pc",    b_pc,    1);
        chk("t5_rst_flush", b_flush, 0);
        chk("t5_rst_stall", b_stall, 0);
        chk("t5_rst_busy",  b_busy,  0);
        tick();
        chk("t5_rst_fcnt", b_fcnt, 0);
        chk("t5_rst_scnt", b_scnt, 0);
        rstn = 1'b1;
        #1;
        chk("t5_run_busy",  b_busy,  0);
        chk("t5_run_flush", b_flush, 0);

        // 6: counter saturation and clear-wins
        do_reset();
        branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        branch_taken = 1'b0;
        #1;
        chk("t6_sat", c_fcnt, 3);
        cnt_clr = 1'b1; branch_taken = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("t6_clr", c_fcnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
